// File: rtl/csr_ex_scheduler.sv
// csr_ex_scheduler: round-robin exception service for NUM_THR thread CSRs.
// Picks one stalled thread, reports its exception to the host over a
// valid/ready handshake, waits for a resume/kill decision, then pulses that
// thread's clr_ex (and kill when requested).
// Optional feature macro: CSR_EX_TIMEOUT_EN adds a response timeout and a
// 'timeout' output; the thread is killed when the host stays silent.
module csr_ex_scheduler #(
    parameter int NUM_THR = 4,
    parameter int IDXW    = $clog2(NUM_THR),
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_THR-1:0]   thr_stall,
    input  logic [6*NUM_THR-1:0] thr_ex_code,
    input  logic [8*NUM_THR-1:0] thr_id,
    output logic [NUM_THR-1:0]   clr_ex,
    output logic [NUM_THR-1:0]   kill,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [IDXW-1:0]      ex_thr_idx,
    output logic [7:0]           ex_thr_id,
    output logic [5:0]           ex_code,
    input  logic                 resp_valid,
    input  logic                 resp_kill,
    output logic                 busy,
`ifdef CSR_EX_TIMEOUT_EN
    output logic                 timeout,
`endif
    output logic [15:0]          ex_count
);

    typedef enum logic [2:0] {IDLE, REPORT, WAIT_RESP, CLEAR, DRAIN} state_t;

    state_t          state_reg, state_next;
    logic [IDXW-1:0] sel_idx_reg;
    logic [IDXW-1:0] rr_ptr_reg;
    logic [5:0]      code_reg;
    logic [7:0]      id_reg;
    logic            resp_kill_reg;
    logic [15:0]     ex_count_reg;

    logic [5:0]      code_arr [NUM_THR];
    logic [7:0]      id_arr   [NUM_THR];
    logic            pick_found;
    logic [IDXW-1:0] pick_idx;

`ifdef CSR_EX_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT) + 1;
    logic [CNTW-1:0] resp_cnt_reg;
    logic            timed_out_reg;
    logic            cnt_expired;
    assign cnt_expired = (resp_cnt_reg == CNTW'(TIMEOUT - 1));
`endif

    // Unpack per-thread lanes, and decode the one-hot clear/kill pulses.
    for (genvar gi = 0; gi < NUM_THR; gi++) begin : g_lane
        assign code_arr[gi] = thr_ex_code[6*gi +: 6];
        assign id_arr[gi]   = thr_id[8*gi +: 8];
        assign clr_ex[gi]   = (state_reg == CLEAR) && (sel_idx_reg == IDXW'(gi));
        assign kill[gi]     = (state_reg == CLEAR) && (sel_idx_reg == IDXW'(gi)) && resp_kill_reg;
    end

    // Round-robin search: first stalled thread after rr_ptr, wrapping.
    always_comb begin : pick_search
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_THR; k++) begin
            cand = (int'(rr_ptr_reg) + k) % NUM_THR;
            if (!pick_found && thr_stall[IDXW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDXW'(cand);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (pick_found) state_next = REPORT;
            REPORT:    if (ex_ready) state_next = WAIT_RESP;
            WAIT_RESP: begin
                if (resp_valid) state_next = CLEAR;
`ifdef CSR_EX_TIMEOUT_EN
                else if (cnt_expired) state_next = CLEAR;
`endif
            end
            CLEAR:     state_next = DRAIN;
            DRAIN:     if (!thr_stall[sel_idx_reg]) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Datapath: latch the report, count handshakes, latch the decision,
    // advance the round-robin pointer once the thread has cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_idx_reg   <= '0;
            rr_ptr_reg    <= IDXW'(NUM_THR - 1);
            code_reg      <= '0;
            id_reg        <= '0;
            resp_kill_reg <= 1'b0;
            ex_count_reg  <= '0;
`ifdef CSR_EX_TIMEOUT_EN
            resp_cnt_reg  <= '0;
            timed_out_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        sel_idx_reg <= pick_idx;
                        code_reg    <= code_arr[pick_idx];
                        id_reg      <= id_arr[pick_idx];
                    end
                end
                REPORT: begin
                    if (ex_ready) begin
                        if (ex_count_reg != 16'hFFFF) ex_count_reg <= ex_count_reg + 16'd1;
`ifdef CSR_EX_TIMEOUT_EN
                        resp_cnt_reg <= '0;
`endif
                    end
                end
                WAIT_RESP: begin
                    if (resp_valid) begin
                        resp_kill_reg <= resp_kill;
`ifdef CSR_EX_TIMEOUT_EN
                        timed_out_reg <= 1'b0;
                    end else if (cnt_expired) begin
                        resp_kill_reg <= 1'b1;
                        timed_out_reg <= 1'b1;
                    end else begin
                        resp_cnt_reg  <= resp_cnt_reg + 1'b1;
`endif
                    end
                end
                DRAIN: begin
                    if (!thr_stall[sel_idx_reg]) rr_ptr_reg <= sel_idx_reg;
                end
                default: ;
            endcase
        end
    end

    assign ex_valid   = (state_reg == REPORT);
    assign busy       = (state_reg != IDLE);
    assign ex_thr_idx = sel_idx_reg;
    assign ex_thr_id  = id_reg;
    assign ex_code    = code_reg;
    assign ex_count   = ex_count_reg;
`ifdef CSR_EX_TIMEOUT_EN
    assign timeout    = (state_reg == CLEAR) && timed_out_reg;
`endif

endmodule

// File: tb/tb_csr_ex_scheduler.sv
// Scoreboard bench for csr_ex_scheduler: stimulus pushes expected reports and
// clear pulses; a negedge monitor pops and compares when the DUT presents them.
module tb_csr_ex_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  thr_stall;
    logic [23:0] thr_ex_code;
    logic [31:0] thr_id;
    logic [3:0]  clr_ex;
    logic [3:0]  kill;
    logic        ex_valid;
    logic        ex_ready;
    logic [1:0]  ex_thr_idx;
    logic [7:0]  ex_thr_id;
    logic [5:0]  ex_code;
    logic        resp_valid;
    logic        resp_kill;
    logic        busy;
    logic [15:0] ex_count;
`ifdef CSR_EX_TIMEOUT_EN
    logic        timeout;
`endif

    csr_ex_scheduler #(.NUM_THR(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .thr_stall(thr_stall), .thr_ex_code(thr_ex_code),
        .thr_id(thr_id), .clr_ex(clr_ex), .kill(kill), .ex_valid(ex_valid),
        .ex_ready(ex_ready), .ex_thr_idx(ex_thr_idx), .ex_thr_id(ex_thr_id),
        .ex_code(ex_code), .resp_valid(resp_valid), .resp_kill(resp_kill),
        .busy(busy),
`ifdef CSR_EX_TIMEOUT_EN
        .timeout(timeout),
`endif
        .ex_count(ex_count)
    );

    always #5 clk = ~clk;

    typedef struct {logic [1:0] idx; logic [7:0] id; logic [5:0] code;} rep_t;
    typedef struct {logic [3:0] clr; logic [3:0] kil;} clr_t;

    rep_t exp_rep[$];
    clr_t exp_clr[$];
    rep_t mon_rep;
    clr_t mon_clr;

    logic [5:0] codes [4] = '{6'h05, 6'h2A, 6'h12, 6'h31};
    logic [7:0] ids   [4] = '{8'hA0, 8'hB1, 8'h02, 8'hD3};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_lanes();
        for (int i = 0; i < 4; i++) begin
            thr_ex_code[6*i +: 6] = codes[i];
            thr_id[8*i +: 8]      = ids[i];
        end
    endtask

    // Monitor: compare handshaken reports and clear pulses against the queues.
    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            if (exp_rep.size() == 0) begin
                chk("report_unexpected", 1, 0);
            end else begin
                mon_rep = exp_rep.pop_front();
                $display("report idx=%0d id=%02h code=%02h", ex_thr_idx, ex_thr_id, ex_code);
                chk("rep_idx", ex_thr_idx, mon_rep.idx);
                chk("rep_id", ex_thr_id, mon_rep.id);
                chk("rep_code", ex_code, mon_rep.code);
            end
        end
        if (clr_ex != 4'b0 || kill != 4'b0) begin
            chk("clr_onehot", $countones(clr_ex), 1);
            chk("kill_subset", kill & ~clr_ex, 0);
            if (exp_clr.size() == 0) begin
                chk("clr_unexpected", 1, 0);
            end else begin
                mon_clr = exp_clr.pop_front();
                $display("clear clr_ex=%04b kill=%04b", clr_ex, kill);
                chk("clr_bits", clr_ex, mon_clr.clr);
                chk("kill_bits", kill, mon_clr.kil);
            end
        end
    end

    // Wait (bounded) for a report, then handshake it in one cycle.
    task automatic handshake(input int idx);
        bit got;
        got = 1'b0;
        exp_rep.push_back('{2'(idx), ids[idx], codes[idx]});
        ex_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (ex_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        chk("ex_valid_wait", got, 1);
        tick();
        ex_ready = 1'b0;
        chk("valid_drop", ex_valid, 0);
    endtask

    // Full service of one thread; emulates the csr clearing its stall.
    task automatic service(input int idx, input logic k, input bit restall);
        handshake(idx);
        exp_clr.push_back('{4'(1 << idx), k ? 4'(1 << idx) : 4'b0});
        resp_valid = 1'b1;
        resp_kill  = k;
        tick();
        resp_valid = 1'b0;
        resp_kill  = 1'b0;
        chk("svc_clr", clr_ex, 1 << idx);
        tick();
        chk("svc_clr_one_cycle", clr_ex, 0);
        thr_stall[idx] = 1'b0;
        tick();
        if (restall) thr_stall[idx] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; thr_stall = '0; ex_ready = 1'b0; resp_valid = 1'b0; resp_kill = 1'b0;
        load_lanes();
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", ex_valid, 0);
        chk("rst_count", ex_count, 0);
        chk("rst_clr", clr_ex, 0);
        chk("rst_kill", kill, 0);
        chk("rst_idx", ex_thr_idx, 0);
        rst = 1'b0;

        // Single report with backpressure; inputs change but outputs stay latched.
        thr_stall = 4'b0100;
        tick();
        chk("t1_valid", ex_valid, 1);
        chk("t1_busy", busy, 1);
        chk("t1_idx", ex_thr_idx, 2);
        chk("t1_id", ex_thr_id, 8'h02);
        chk("t1_code", ex_code, 6'h12);
        exp_rep.push_back('{2'd2, 8'h02, 6'h12});
        thr_ex_code[12 +: 6] = 6'h3F;
        thr_id[16 +: 8]      = 8'hFF;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("t1_hold_valid", ex_valid, 1);
            chk("t1_hold_idx", ex_thr_idx, 2);
            chk("t1_hold_id", ex_thr_id, 8'h02);
            chk("t1_hold_code", ex_code, 6'h12);
        end
        load_lanes();
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
        chk("t1_valid_drop", ex_valid, 0);
        chk("t1_count", ex_count, 1);
        chk("t1_wait_busy", busy, 1);
        exp_clr.push_back('{4'b0100, 4'b0000});
        resp_valid = 1'b1;
        tick();
        resp_valid = 1'b0;
        chk("t1_clr", clr_ex, 4'b0100);
        chk("t1_kill", kill, 0);
        tick();
        chk("t1_clr_once", clr_ex, 0);
        chk("t1_drain_busy", busy, 1);
        thr_stall = 4'b0000;
        tick();
        chk("t1_idle", busy, 0);

        // Reset during WAIT_RESP aborts the service.
        thr_stall = 4'b0100;
        handshake(2);
        tick();
        chk("rs_waiting", busy, 1);
        rst = 1'b1;
        thr_stall = 4'b0000;
        tick();
        chk("rs_busy", busy, 0);
        chk("rs_valid", ex_valid, 0);
        chk("rs_count", ex_count, 0);
        chk("rs_clr", clr_ex, 0);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("rs_no_clr", clr_ex, 0);
        end

        // Held simultaneous stalls: strict round-robin 0,1,3,0,1,3.
        thr_stall = 4'b1011;
        service(0, 1'b0, 1'b1);
        service(1, 1'b0, 1'b1);
        service(3, 1'b1, 1'b1);
        service(0, 1'b0, 1'b0);
        service(1, 1'b1, 1'b0);
        service(3, 1'b0, 1'b0);
        tick();
        chk("rr_count", ex_count, 6);
        chk("rr_idle", busy, 0);

`ifdef CSR_EX_TIMEOUT_EN
        // Host silent: thread killed 8 cycles after entering WAIT_RESP.
        thr_stall = 4'b0010;
        handshake(1);
        exp_clr.push_back('{4'b0010, 4'b0010});
        for (int n = 0; n < 7; n++) begin
            tick();
            chk("to_wait_clr", clr_ex, 0);
            chk("to_wait_flag", timeout, 0);
        end
        tick();
        chk("to_clr", clr_ex, 4'b0010);
        chk("to_kill", kill, 4'b0010);
        chk("to_flag", timeout, 1);
        tick();
        chk("to_flag_once", timeout, 0);
        thr_stall = 4'b0000;
        tick();
        tick();
`endif

        chk("rep_queue_empty", exp_rep.size(), 0);
        chk("clr_queue_empty", exp_clr.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
